// File: rtl/mesi_cpu_req_ctrl_array_pkg.sv
// Shared definitions for the MESI request controller.
// Covers line states, bus request/response codes, lookup outcomes and FSM states.
package mesi_cpu_req_ctrl_array_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_state_t;

  typedef enum logic [1:0] {
    BUS_NO_REQ         = 2'd0,
    BUS_READ_REQ       = 2'd1,
    BUS_RWITM_REQ      = 2'd2,
    BUS_INVALIDATE_REQ = 2'd3
  } bus_req_t;

  // Encoding 3 is reserved and behaves like BUS_NO_RSP.
  localparam logic [1:0] BUS_NO_RSP          = 2'd0;
  localparam logic [1:0] BUS_SNOOP_FOUND_RSP = 2'd1;
  localparam logic [1:0] BUS_FETCH_MEM_RSP   = 2'd2;

  typedef enum logic [1:0] {
    READ_HIT   = 2'd0,
    READ_MISS  = 2'd1,
    WRITE_HIT  = 2'd2,
    WRITE_MISS = 2'd3
  } cpu_access_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_WB       = 3'd2,
    ST_BUS_REQ  = 3'd3,
    ST_WAIT_RSP = 3'd4,
    ST_RESP     = 3'd5
  } ctrl_state_t;

  function automatic cpu_access_t classify(input logic rw, input logic hit);
    cpu_access_t kind;
    case ({rw, hit})
      2'b00:   kind = READ_MISS;
      2'b01:   kind = READ_HIT;
      2'b10:   kind = WRITE_MISS;
      default: kind = WRITE_HIT;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/mesi_cpu_req_ctrl_array_if.sv
// CPU, bus, write-back and snoop signals of the MESI controller.
// The controller uses the slave view; the CPU/bus environment uses the master view.
interface mesi_cpu_req_ctrl_array_if #(parameter int ADDR_W = 32);
  logic              cpu_req_valid;
  logic              cpu_req_rw;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_req_ready;
  logic              cpu_rsp_valid;
  logic              cpu_rsp_hit;
  logic              cpu_rsp_err;
  logic [1:0]        bus_req;
  logic [ADDR_W-1:0] bus_req_addr;
  logic              bus_gnt;
  logic [1:0]        bus_rsp;
  logic              write_back;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_done;
  logic              snoop_valid;
  logic [1:0]        snoop_op;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_hit;
  logic              snoop_dirty;

  modport master (
    output cpu_req_valid, cpu_req_rw, cpu_req_addr, bus_gnt, bus_rsp, wb_done,
           snoop_valid, snoop_op, snoop_addr,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit, cpu_rsp_err, bus_req, bus_req_addr,
           write_back, wb_addr, snoop_hit, snoop_dirty
  );

  modport slave (
    input  cpu_req_valid, cpu_req_rw, cpu_req_addr, bus_gnt, bus_rsp, wb_done,
           snoop_valid, snoop_op, snoop_addr,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit, cpu_rsp_err, bus_req, bus_req_addr,
           write_back, wb_addr, snoop_hit, snoop_dirty
  );
endinterface

// File: rtl/mesi_cpu_req_ctrl_array_line_array.sv
// MESI state and tag storage: one CPU read/write port, one snoop read-modify-write port.
// A CPU-side write to the same line as a snoop update takes priority.
module mesi_cpu_req_ctrl_array_line_array
  import mesi_cpu_req_ctrl_array_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int TAG_W     = 24,
  localparam int IDX_W    = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_cpu_idx,
  output mesi_state_t      o_cpu_state,
  output logic [TAG_W-1:0] o_cpu_tag,
  input  logic             i_cpu_we,
  input  mesi_state_t      i_cpu_state,
  input  logic             i_cpu_tag_we,
  input  logic [TAG_W-1:0] i_cpu_tag,
  input  logic             i_snoop_valid,
  input  bus_req_t         i_snoop_op,
  input  logic [IDX_W-1:0] i_snoop_idx,
  input  logic [TAG_W-1:0] i_snoop_tag,
  output logic             o_snoop_hit,
  output logic             o_snoop_dirty
);

  mesi_state_t      r_state [NUM_LINES];
  logic [TAG_W-1:0] r_tag   [NUM_LINES];
  logic             r_snoop_hit;
  logic             r_snoop_dirty;

  mesi_state_t w_snp_cur;
  mesi_state_t w_snp_next;
  logic        w_snp_match;
  logic        w_snp_we;

  assign o_cpu_state   = r_state[i_cpu_idx];
  assign o_cpu_tag     = r_tag[i_cpu_idx];
  assign o_snoop_hit   = r_snoop_hit;
  assign o_snoop_dirty = r_snoop_dirty;

  assign w_snp_cur   = r_state[i_snoop_idx];
  assign w_snp_match = i_snoop_valid && (w_snp_cur != MESI_I) && (r_tag[i_snoop_idx] == i_snoop_tag);
  assign w_snp_we    = w_snp_match && !(i_cpu_we && (i_cpu_idx == i_snoop_idx));

  always_comb begin
    w_snp_next = w_snp_cur;
    case (i_snoop_op)
      BUS_READ_REQ:       if (w_snp_cur == MESI_E || w_snp_cur == MESI_M) w_snp_next = MESI_S;
      BUS_RWITM_REQ,
      BUS_INVALIDATE_REQ: w_snp_next = MESI_I;
      default:            w_snp_next = w_snp_cur;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        r_state[i] <= MESI_I;
        r_tag[i]   <= '0;
      end
      r_snoop_hit   <= 1'b0;
      r_snoop_dirty <= 1'b0;
    end else begin
      if (w_snp_we)     r_state[i_snoop_idx] <= w_snp_next;
      if (i_cpu_we)     r_state[i_cpu_idx]   <= i_cpu_state;
      if (i_cpu_tag_we) r_tag[i_cpu_idx]     <= i_cpu_tag;
      r_snoop_hit   <= w_snp_match;
      r_snoop_dirty <= w_snp_match && (w_snp_cur == MESI_M);
    end
  end

endmodule

// File: rtl/mesi_cpu_req_ctrl_array.sv
// Sequential MESI CPU-request controller for a direct-mapped cache.
// Handles lookup, victim write-back, bus request/grant, fill response and snoops.
module mesi_cpu_req_ctrl_array
  import mesi_cpu_req_ctrl_array_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int OFFSET_W  = 4,
  parameter int NUM_LINES = 16,
  parameter int TIMEOUT   = 255
) (
  input logic                      clk,
  input logic                      rst_n,
  mesi_cpu_req_ctrl_array_if.slave bus_if
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - OFFSET_W - IDX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  ctrl_state_t       r_state, w_next;
  logic              r_rw;
  logic [LINE_W-1:0] r_line;
  bus_req_t          r_pending;
  logic              r_hit, r_err, r_ready;
  logic [CNT_W-1:0]  r_cnt;
  logic [TAG_W-1:0]  r_victim_tag;

  logic [IDX_W-1:0]  w_idx, w_snp_idx;
  logic [TAG_W-1:0]  w_tag, w_snp_tag, w_line_tag;
  mesi_state_t       w_line_state, w_wstate;
  logic              w_line_hit, w_stall, w_kill, w_accept, w_timeout, w_fill;
  logic              w_we, w_tag_we;
  bus_req_t          w_snoop_op, w_eff_op;

  assign w_idx      = r_line[IDX_W-1:0];
  assign w_tag      = r_line[LINE_W-1 -: TAG_W];
  assign w_snp_idx  = bus_if.snoop_addr[OFFSET_W +: IDX_W];
  assign w_snp_tag  = bus_if.snoop_addr[ADDR_W-1 -: TAG_W];
  assign w_snoop_op = bus_req_t'(bus_if.snoop_op);
  assign w_line_hit = (w_line_state != MESI_I) && (w_line_tag == w_tag);
  assign w_accept   = bus_if.cpu_req_valid && r_ready;
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_fill     = (bus_if.bus_rsp == BUS_SNOOP_FOUND_RSP) || (bus_if.bus_rsp == BUS_FETCH_MEM_RSP);
  assign w_stall    = bus_if.snoop_valid && (w_snoop_op != BUS_NO_REQ) && (w_snp_idx == w_idx);
  // A snoop that kills our S copy turns a pending upgrade into a full RWITM.
  assign w_kill     = bus_if.snoop_valid
                   && (w_snoop_op == BUS_RWITM_REQ || w_snoop_op == BUS_INVALIDATE_REQ)
                   && (w_snp_idx == w_idx) && (w_snp_tag == w_line_tag) && (w_line_state != MESI_I);
  assign w_eff_op   = (r_pending == BUS_INVALIDATE_REQ && w_kill) ? BUS_RWITM_REQ : r_pending;
  assign bus_if.cpu_req_ready = r_ready;

  mesi_cpu_req_ctrl_array_line_array #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W)) u_array (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cpu_idx     (w_idx),
    .o_cpu_state   (w_line_state),
    .o_cpu_tag     (w_line_tag),
    .i_cpu_we      (w_we),
    .i_cpu_state   (w_wstate),
    .i_cpu_tag_we  (w_tag_we),
    .i_cpu_tag     (w_tag),
    .i_snoop_valid (bus_if.snoop_valid),
    .i_snoop_op    (w_snoop_op),
    .i_snoop_idx   (w_snp_idx),
    .i_snoop_tag   (w_snp_tag),
    .o_snoop_hit   (bus_if.snoop_hit),
    .o_snoop_dirty (bus_if.snoop_dirty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_LOOKUP;
      ST_LOOKUP: if (!w_stall) begin
        case (classify(r_rw, w_line_hit))
          READ_HIT:  w_next = ST_RESP;
          WRITE_HIT: w_next = (w_line_state == MESI_S) ? ST_BUS_REQ : ST_RESP;
          default:   w_next = (w_line_state == MESI_M) ? ST_WB : ST_BUS_REQ;
        endcase
      end
      ST_WB:       if (bus_if.wb_done) w_next = ST_BUS_REQ;
      ST_BUS_REQ:  if (bus_if.bus_gnt) w_next = (w_eff_op == BUS_INVALIDATE_REQ) ? ST_RESP : ST_WAIT_RSP;
      ST_WAIT_RSP: if (w_fill || w_timeout) w_next = ST_RESP;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we                 = 1'b0;
    w_wstate             = MESI_I;
    w_tag_we             = 1'b0;
    bus_if.bus_req       = BUS_NO_REQ;
    bus_if.bus_req_addr  = '0;
    bus_if.write_back    = 1'b0;
    bus_if.wb_addr       = '0;
    bus_if.cpu_rsp_valid = 1'b0;
    bus_if.cpu_rsp_hit   = 1'b0;
    bus_if.cpu_rsp_err   = 1'b0;
    case (r_state)
      ST_LOOKUP: if (!w_stall && w_line_hit && r_rw && w_line_state != MESI_S) begin
        w_we     = 1'b1;
        w_wstate = MESI_M;
      end
      ST_WB: begin
        bus_if.write_back = 1'b1;
        bus_if.wb_addr    = {r_victim_tag, w_idx, {OFFSET_W{1'b0}}};
        w_we              = bus_if.wb_done;
      end
      ST_BUS_REQ: begin
        bus_if.bus_req      = r_pending;
        bus_if.bus_req_addr = {w_tag, w_idx, {OFFSET_W{1'b0}}};
        if (bus_if.bus_gnt && w_eff_op == BUS_INVALIDATE_REQ) begin
          w_we     = 1'b1;
          w_wstate = MESI_M;
        end
      end
      ST_WAIT_RSP: begin
        if (w_fill) begin
          w_we     = 1'b1;
          w_tag_we = 1'b1;
          w_wstate = r_rw ? MESI_M : ((bus_if.bus_rsp == BUS_SNOOP_FOUND_RSP) ? MESI_S : MESI_E);
        end else if (w_timeout) begin
          w_we = 1'b1;
        end
      end
      ST_RESP: begin
        bus_if.cpu_rsp_valid = 1'b1;
        bus_if.cpu_rsp_hit   = r_hit;
        bus_if.cpu_rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  // Datapath registers; ready is registered so it stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready      <= 1'b0;
      r_rw         <= 1'b0;
      r_line       <= '0;
      r_pending    <= BUS_NO_REQ;
      r_hit        <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_victim_tag <= '0;
    end else begin
      r_ready <= (w_next == ST_IDLE);
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_rw   <= bus_if.cpu_req_rw;
          r_line <= bus_if.cpu_req_addr[ADDR_W-1:OFFSET_W];
          r_hit  <= 1'b0;
          r_err  <= 1'b0;
        end
        ST_LOOKUP: if (!w_stall) begin
          r_hit        <= w_line_hit;
          r_victim_tag <= w_line_tag;
          r_pending    <= w_line_hit ? BUS_INVALIDATE_REQ : (r_rw ? BUS_RWITM_REQ : BUS_READ_REQ);
        end
        ST_BUS_REQ: begin
          r_pending <= w_eff_op;
          r_cnt     <= '0;
        end
        ST_WAIT_RSP: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_fill && w_timeout) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mesi_cpu_req_ctrl_array.md
Name: mesi_cpu_req_ctrl_array

Overview:
- Sequential, parametrised successor to the combinational MESI CPU-request decoder.
- Owns the MESI state and tag array for a direct-mapped cache of NUM_LINES lines.
- Accepts one CPU request at a time over a valid/ready handshake, performs lookup, victim write-back, bus request/grant and response wait, and applies incoming snoops.
- Sits between the CPU port and the shared snooping bus arbiter.

Parameters:
- ADDR_W, 32, CPU/bus address width.
- OFFSET_W, 4, line-offset bits (ignored for lookup; zeroed on bus addresses).
- NUM_LINES, 16, cache lines; power of two ≥ 2. IDX_W = log2(NUM_LINES). TAG_W = ADDR_W − OFFSET_W − IDX_W.
- TIMEOUT, 255, maximum WAIT_RSP cycles before abort (≥ 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  request present.
- cpu_req_rw  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_W  request address.
- cpu_req_ready  out  1  request accepted when valid && ready.
- cpu_rsp_valid  out  1  one-cycle completion pulse.
- cpu_rsp_hit  out  1  completion was a hit (qualified by cpu_rsp_valid).
- cpu_rsp_err  out  1  completion aborted by timeout (qualified by cpu_rsp_valid).
- bus_req  out  2  BUS_NO_REQ / BUS_READ_REQ / BUS_RWITM_REQ / BUS_INVALIDATE_REQ.
- bus_req_addr  out  ADDR_W  {tag, idx, OFFSET_W'b0}.
- bus_gnt  in  1  arbiter grant.
- bus_rsp  in  2  BUS_NO_RSP / BUS_SNOOP_FOUND_RSP / BUS_FETCH_MEM_RSP.
- write_back  out  1  victim write-back request.
- wb_addr  out  ADDR_W  victim line address.
- wb_done  in  1  write-back complete.
- snoop_valid  in  1  snoop from another cache.
- snoop_op  in  2  bus_req encoding of the snooped transaction.
- snoop_addr  in  ADDR_W  snooped address.
- snoop_hit  out  1  registered; line was valid (S/E/M) the cycle before.
- snoop_dirty  out  1  registered; line was M the cycle before (this cache supplies data).

Behaviour:
- Reset: all lines INVALID, tags 0, FSM IDLE. All outputs 0, including cpu_req_ready. Reset asserted mid-transaction drops everything with no completion pulse.
- FSM states: IDLE, LOOKUP, WB, BUS_REQ, WAIT_RSP, RESP.
- IDLE: cpu_req_ready = 1. On handshake, latch rw/addr and go to LOOKUP. Minimum hit latency is 3 cycles, accept to cpu_rsp_valid.
- LOOKUP:
  - hit = state ≠ INVALID && tag match.
  - Read hit → RESP, state unchanged.
  - Write hit on E/M → state M → RESP.
  - Write hit on S → pending op INVALIDATE → BUS_REQ.
  - Miss with victim M → WB. Miss otherwise → BUS_REQ with pending READ (read) or RWITM (write).
- WB: write_back = 1, wb_addr = victim address. On wb_done: victim → INVALID, go to BUS_REQ.
- BUS_REQ: bus_req = pending op, held until the bus_gnt cycle inclusive, then BUS_NO_REQ.
  - INVALIDATE granted → line M → RESP.
  - READ/RWITM granted → WAIT_RSP, timeout counter cleared.
- WAIT_RSP:
  - SNOOP_FOUND: read → S, write → M.
  - FETCH_MEM: read → E, write → M.
  - Tag written on response; go to RESP.
  - BUS_NO_RSP: counter increments. On reaching TIMEOUT, line stays INVALID and RESP is entered with err set.
  - Reserved rsp encoding is treated as NO_RSP.
- RESP: cpu_rsp_valid = 1 for one cycle with hit/err, then IDLE. cpu_rsp_hit = 1 only for LOOKUP hits, including the S-upgrade path.
- Snoops: processed every cycle, independent of the FSM. A snoop matching a valid line (same idx, tag):
  - READ: E/M → S.
  - RWITM/INVALIDATE: → INVALID.
  - snoop_hit/snoop_dirty reflect the pre-update state, one cycle later.
- Simultaneous events:
  - Snoop and LOOKUP on the same idx in the same cycle: the snoop wins and LOOKUP stalls one cycle, re-evaluating the updated state.
  - Snoop invalidates our S line while pending op = INVALIDATE (in BUS_REQ before grant): pending op becomes RWITM, and the grant leads to WAIT_RSP.
  - Snoop and fill write the same line in the same cycle: the fill wins.
- No new request is accepted outside IDLE.

Decomposition:
- Shared header cache_def holds the MESI state codes, BUS_*_REQ/RSP codes, and READ/WRITE_HIT/MISS codes.
- Add FSM state codes to cache_def.
- One sub-module, mesi_line_array: state + tag storage with one CPU-side read/write port and one snoop read-modify-write port, plus the snoop/fill priority logic.

Test Plan:
- Reset, then read 0x0000_0040 with FETCH_MEM 2 cycles after grant → bus_req = READ, addr 0x40; line E; cpu_rsp_valid with hit = 0.
- Repeat the read, then write 0x40 → both hit, no bus_req, no bus activity; line M.
- Read 0x0000_0440 (same idx 4, new tag) with line M → write_back with wb_addr 0x40; after wb_done, bus_req READ 0x440; SNOOP_FOUND → S.
- Write 0x440 in S → bus_req INVALIDATE; grant → M, hit = 1. Repeat with snoop RWITM 0x440 before grant → bus_req changes to RWITM; bus_rsp required.
- Snoop READ 0x440 while line M → next cycle snoop_hit = 1, snoop_dirty = 1; line S.
- Read miss, grant, bus_rsp held NO_RSP for 255 cycles → cpu_rsp_valid with err = 1; line INVALID; FSM IDLE. Assert rst_n low in WAIT_RSP → all outputs 0 immediately.
